bcd_display_sequencer: RTL and testbench

Multi-cycle controller that sequences a shift-and-add-3 (double-dabble) binary-to-BCD conversion of a 16-bit value and time-multiplexes the four resulting BCD digits onto a common-anode 4-digit 7-segment display. It sits between the MIPS32 core's display/debug register and the board's segment decoder. A start/busy/done handshake drives the conversion. The displayed value only changes on conversion completion, so the scan never shows a half-converted result.

---
 rtl/bcd_display_sequencer.sv | 170 +++++++++++++++++
 tb/tb_bcd_display_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_sequencer.sv
// bcd_display_sequencer
//   Converts a 16-bit unsigned value to four packed BCD digits by double-dabble.
//   The conversion takes a fixed 18 cycles. The last converted value is
//   time-multiplexed onto a common-anode 4-digit 7-segment display.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays selected (>= 2)
//
// Build option
//   BCD_LEADING_ZERO_BLANK_EN  when defined, leading-zero digits (never the
//                              ones digit) are blanked and their anode is
//                              released. When undefined, blank is held at 0.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   start     conversion request, sampled in IDLE only
//   binary    value to convert, captured on the accepting edge
//   busy      high from LOAD through the last SHIFT cycle
//   done      one-cycle pulse when bcd/overflow update
//   bcd       {thousands, hundreds, tens, ones}, registered
//   overflow  last converted value was > 9999 (bcd then reads 9999)
//   an        active-low one-hot anode select, bit 0 = ones digit
//   digit     BCD nibble of the selected position
//   blank     selected position must be dark
module bcd_display_sequencer #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] binary,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        blank
);

    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] shreg;
    logic [15:0] scratch;
    logic [15:0] scratch_adj;
    logic [4:0]  iter;
    logic        ovf_cand;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  state_next = SHIFT;
            SHIFT: if (iter == 5'd15) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == LOAD) || (state == SHIFT);

    // Add-3 correction on every nibble >= 5, applied before the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int n = 0; n < 4; n++) begin
            if (scratch[4*n +: 4] >= 4'd5)
                scratch_adj[4*n +: 4] = scratch[4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            scratch  <= '0;
            iter     <= '0;
            ovf_cand <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= binary;
                        ovf_cand <= (binary > 16'd9999);
                    end
                end
                LOAD: begin
                    scratch <= '0;
                    iter    <= '0;
                end
                SHIFT: begin
                    // scratch[15] falls off; binary MSB enters scratch[0].
                    scratch <= {scratch_adj[14:0], shreg[15]};
                    shreg   <= {shreg[14:0], 1'b0};
                    iter    <= iter + 5'd1;
                end
                DONE: begin
                    // Output registers change only here, so the scan never
                    // sees a partially converted value.
                    bcd      <= ovf_cand ? 16'h9999 : scratch;
                    overflow <= ovf_cand;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- display scanner ----------------
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic          wrap;
    logic          blank_next;
    logic [3:0]    an_next;
    logic [3:0]    one_hot;

    assign wrap     = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign idx_next = wrap ? idx + 2'd1 : idx;
    assign one_hot  = 4'b0001 << idx_next;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // A position is dark when it and every higher nibble are zero.
    always_comb begin
        blank_next = 1'b0;
        case (idx_next)
            2'd3: blank_next = (bcd[15:12] == 4'd0);
            2'd2: blank_next = (bcd[15:8]  == 8'd0);
            2'd1: blank_next = (bcd[15:4]  == 12'd0);
            default: blank_next = 1'b0;
        endcase
    end
`else
    assign blank_next = 1'b0;
`endif

    assign an_next = blank_next ? 4'b1111 : ~one_hot;

    // digit/blank track the registered bcd, so they follow a bcd update one
    // cycle later; on a coincident wrap the new index picks up the new bcd on
    // the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
            an          <= 4'b1110;
            digit       <= '0;
            blank       <= 1'b0;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + RW'(1);
            idx         <= idx_next;
            an          <= an_next;
            digit       <= bcd[4*idx_next +: 4];
            blank       <= blank_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_sequencer.sv
module tb_bcd_display_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] binary;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        blank;

    int total = 0;
    int bad   = 0;
    logic [16:0] sb[$];   // {bcd, overflow} expected per accepted start

    bcd_display_sequencer #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .binary(binary),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow),
        .an(an), .digit(digit), .blank(blank)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [15:0] v);
        int x;
        x = v;
        if (x > 9999) return {16'h9999, 1'b1};
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10), 1'b0};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; binary = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bcd, overflow, busy, done} !== 19'd0) begin
            bad++;
            $display("FAIL reset_state got bcd=%h ovf=%b busy=%b done=%b want 0", bcd, overflow, busy, done);
        end
        total++;
        if ({an, digit, blank} !== {4'b1110, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_scan got an=%b digit=%h blank=%b want 1110 0 0", an, digit, blank);
        end
    endtask

    // Drives one conversion and checks busy/done timing and the result.
    task automatic test_convert(input logic [15:0] v);
        logic [16:0] exp;
        @(negedge clk);
        binary = v; start = 1'b1;
        @(posedge clk);                    // accepting edge E
        sb.push_back(model(v));
        for (int n = 0; n <= 17; n++) begin
            @(negedge clk);                // after edge E+n
            start = 1'b0;
            total++;
            if (busy !== (n <= 16) || done !== 1'b0) begin
                bad++;
                $display("FAIL conv_%0d_timing n=%0d got busy=%b done=%b want busy=%b done=0",
                         v, n, busy, done, (n <= 16));
            end
        end
        @(negedge clk);                    // after E+18
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL conv_%0d_done got %b want 1", v, done);
        end
        exp = sb.pop_front();
        total++;
        if ({bcd, overflow} !== exp) begin
            bad++;
            $display("FAIL conv_%0d_result got bcd=%h ovf=%b want bcd=%h ovf=%b",
                     v, bcd, overflow, exp[16:1], exp[0]);
        end
        @(negedge clk);                    // after E+19
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL conv_%0d_pulse got done=%b want 0", v, done);
        end
    endtask

    task automatic test_values();
        test_convert(16'd1234);
        test_convert(16'd0);
        test_convert(16'd9999);
        test_convert(16'd10000);
        test_convert(16'd65535);
        test_convert(16'd8642);
    endtask

    // start re-asserted while busy and while in DONE must be dropped.
    task automatic test_back_to_back();
        int dones;
        logic [16:0] exp;
        @(negedge clk);
        binary = 16'd777; start = 1'b1;
        @(posedge clk);
        sb.push_back(model(16'd777));
        dones = 0;
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                exp = sb.pop_front();
                total++;
                if (n != 18 || {bcd, overflow} !== exp) begin
                    bad++;
                    $display("FAIL ignore_result n=%0d got bcd=%h ovf=%b want n=18 bcd=%h ovf=%b",
                             n, bcd, overflow, exp[16:1], exp[0]);
                end
            end
            start = 1'b0;
            if (n == 3)  begin start = 1'b1; binary = 16'd42; end
            if (n == 16 || n == 17) begin start = 1'b1; binary = 16'd42; end
        end
        start = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL ignore_busy n=%0d got busy=%b want 0", n, busy);
            end
        end
        total++;
        if (dones != 1 || bcd !== 16'h0777) begin
            bad++;
            $display("FAIL ignore_single got dones=%0d bcd=%h want dones=1 bcd=0777", dones, bcd);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        binary = 16'd1234; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({bcd, overflow, busy, done} !== 19'd0 || an !== 4'b1110) begin
            bad++;
            $display("FAIL midreset_state got bcd=%h ovf=%b busy=%b done=%b an=%b want 0 0 0 0 1110",
                     bcd, overflow, busy, done, an);
        end
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || bcd !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_nodone got dones=%0d bcd=%h want 0 0000", dones, bcd);
        end
    endtask

    task automatic test_scan();
        logic [15:0] val;
        logic [3:0]  prev_an, exp_an, exp_dig, one;
        logic        exp_blank, found;
        int          k;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        val = 16'h0007;
        test_convert(16'd7);
`else
        val = 16'h0507;
        test_convert(16'd507);
`endif
        prev_an = an;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (an === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
            else prev_an = an;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL scan_align got an=%b want transition into 1110 within 20 cycles", an);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i != 0) @(negedge clk);
                k = i / 4;
                one = 4'b0001;
`ifdef BCD_LEADING_ZERO_BLANK_EN
                exp_blank = (k != 0);
                exp_an    = exp_blank ? 4'b1111 : 4'b1110;
                exp_dig   = (k == 0) ? 4'h7 : 4'h0;
`else
                exp_blank = 1'b0;
                exp_an    = ~(one << k);
                exp_dig   = val[4*k +: 4];
`endif
                total++;
                if (an !== exp_an || digit !== exp_dig || blank !== exp_blank) begin
                    bad++;
                    $display("FAIL scan_i%0d got an=%b digit=%h blank=%b want an=%b digit=%h blank=%b",
                             i, an, digit, blank, exp_an, exp_dig, exp_blank);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_back_to_back();
        test_reset_mid();
        test_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
